// File: rtl/conv_acc_ctrl.sv
// Convolution output-pixel sequencer: bias pre-load, TAPS-beat MAC accumulation,
// Q16.16 -> Q8.8 truncation with optional ReLU, and a valid/ready result port.
module conv_acc_ctrl #(
    parameter int INTERNAL_BITS = 32,
    parameter int DATA_BITS     = 16,
    parameter int FRAC_BITS     = 8,
    parameter int TAPS          = 9,
    parameter int CNT_W         = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [DATA_BITS-1:0]     bias,
    input  logic                     relu_en,
    input  logic                     prod_valid,
    output logic                     prod_ready,
    input  logic [INTERNAL_BITS-1:0] prod_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_BITS-1:0]     out_data,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                   state_q;
    logic [INTERNAL_BITS-1:0] acc_q;
    logic [INTERNAL_BITS-1:0] acc_d;
    logic [INTERNAL_BITS-1:0] bias_ext;
    logic [CNT_W-1:0]         cnt_q;
    logic                     relu_q;
    logic [DATA_BITS-1:0]     out_data_q;
    logic [DATA_BITS-1:0]     result_d;
    logic                     done_q;
    logic                     beat;

    assign bias_ext = {{(INTERNAL_BITS-DATA_BITS){bias[DATA_BITS-1]}}, bias};
    assign beat     = prod_valid && (state_q == ACC);
    assign acc_d    = acc_q + prod_data;

    // ReLU looks at the sign of the full accumulator, not of the truncated slice.
    assign result_d = (relu_q && acc_d[INTERNAL_BITS-1]) ? '0
                    : acc_d[FRAC_BITS+DATA_BITS-1:FRAC_BITS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            cnt_q      <= '0;
            relu_q     <= 1'b0;
            out_data_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= bias_ext << FRAC_BITS;
                        cnt_q   <= '0;
                        relu_q  <= relu_en;
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(TAPS-1)) begin
                            out_data_q <= result_d;
                            state_q    <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign prod_ready = (state_q == ACC);
    assign out_valid  = (state_q == OUT);
    assign busy       = (state_q != IDLE);
    assign out_data   = out_data_q;
    assign done       = done_q;

endmodule

// File: tb/tb_conv_acc_ctrl.sv
// Directed testbench for conv_acc_ctrl; each task drives one scenario and checks inline.
module tb_conv_acc_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] bias;
    logic        relu_en;
    logic        prod_valid;
    logic        prod_ready;
    logic [31:0] prod_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic        done;

    int checkCount = 0;
    int passCount  = 0;

    conv_acc_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bias       (bias),
        .relu_en    (relu_en),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .prod_data  (prod_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks begin and end 1 time unit after a rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic startJob(input logic [15:0] b, input logic r);
        start   = 1'b1;
        bias    = b;
        relu_en = r;
        nextCycle();
        start   = 1'b0;
    endtask

    task automatic sendBeat(input logic [31:0] d);
        prod_valid = 1'b1;
        prod_data  = d;
        nextCycle();
        prod_valid = 1'b0;
    endtask

    task automatic runJob(input logic [15:0] b, input logic r, input logic [31:0] d0,
                          input logic [31:0] drest, output logic [15:0] res);
        startJob(b, r);
        sendBeat(d0);
        for (int i = 0; i < 8; i++) sendBeat(drest);
        for (int k = 0; k < 20 && out_valid !== 1'b1; k++) nextCycle();
        checkCount++;
        if (out_valid !== 1'b1) $display("[TB] FAIL runJob_timeout: out_valid=%b required 1", out_valid);
        else passCount++;
        res       = out_data;
        out_ready = 1'b1;
        nextCycle();
        out_ready = 1'b0;
        nextCycle();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) nextCycle();
        checkCount++;
        if (busy !== 1'b0 || prod_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0)
            $display("[TB] FAIL reset_ctrl: busy=%b prod_ready=%b out_valid=%b done=%b required all 0",
                     busy, prod_ready, out_valid, done);
        else passCount++;
        checkCount++;
        if (out_data !== 16'h0000) $display("[TB] FAIL reset_data: got %h required 0000", out_data);
        else passCount++;
        rst = 1'b1;
        nextCycle();
        checkCount++;
        if (busy !== 1'b0) $display("[TB] FAIL reset_release_idle: busy=%b required 0", busy);
        else passCount++;
    endtask

    task automatic test_basic();
        startJob(16'h0100, 1'b0);
        checkCount++;
        if (prod_ready !== 1'b1 || busy !== 1'b1)
            $display("[TB] FAIL basic_acc_entry: prod_ready=%b busy=%b required 1 1", prod_ready, busy);
        else passCount++;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) begin
                checkCount++;
                if (out_valid !== 1'b0) $display("[TB] FAIL basic_early_valid: out_valid=%b at cycle 9 required 0", out_valid);
                else passCount++;
            end
            sendBeat(32'h0001_0000);
        end
        checkCount++;
        if (out_valid !== 1'b1 || prod_ready !== 1'b0 || busy !== 1'b1)
            $display("[TB] FAIL basic_cycle10: out_valid=%b prod_ready=%b busy=%b required 1 0 1",
                     out_valid, prod_ready, busy);
        else passCount++;
        checkCount++;
        if (out_data !== 16'h0A00) $display("[TB] FAIL basic_data: got %h required 0A00", out_data);
        else passCount++;
        out_ready = 1'b1;
        nextCycle();
        out_ready = 1'b0;
        checkCount++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("[TB] FAIL basic_done: done=%b out_valid=%b busy=%b required 1 0 0", done, out_valid, busy);
        else passCount++;
        nextCycle();
        checkCount++;
        if (done !== 1'b0 || out_data !== 16'h0A00)
            $display("[TB] FAIL basic_after: done=%b out_data=%h required 0 0A00", done, out_data);
        else passCount++;
    endtask

    task automatic test_gaps();
        startJob(16'h0100, 1'b0);
        for (int i = 0; i < 4; i++) sendBeat(32'h0001_0000);
        for (int i = 0; i < 3; i++) nextCycle();
        checkCount++;
        if (prod_ready !== 1'b1 || out_valid !== 1'b0)
            $display("[TB] FAIL gaps_hold: prod_ready=%b out_valid=%b required 1 0", prod_ready, out_valid);
        else passCount++;
        for (int i = 0; i < 5; i++) sendBeat(32'h0001_0000);
        prod_valid = 1'b1;
        prod_data  = 32'h7FFF_0000;
        for (int i = 0; i < 5; i++) begin
            checkCount++;
            if (out_valid !== 1'b1 || prod_ready !== 1'b0 || out_data !== 16'h0A00)
                $display("[TB] FAIL gaps_out_stall%0d: out_valid=%b prod_ready=%b out_data=%h required 1 0 0A00",
                         i, out_valid, prod_ready, out_data);
            else passCount++;
            nextCycle();
        end
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        nextCycle();
        out_ready  = 1'b0;
        checkCount++;
        if (done !== 1'b1 || out_data !== 16'h0A00)
            $display("[TB] FAIL gaps_done: done=%b out_data=%h required 1 0A00", done, out_data);
        else passCount++;
        nextCycle();
    endtask

    task automatic test_relu();
        logic [15:0] res;
        runJob(16'hFF00, 1'b1, 32'h0, 32'h0, res);
        checkCount++;
        if (res !== 16'h0000) $display("[TB] FAIL relu_neg_bias_on: got %h required 0000", res);
        else passCount++;
        runJob(16'hFF00, 1'b0, 32'h0, 32'h0, res);
        checkCount++;
        if (res !== 16'hFF00) $display("[TB] FAIL relu_neg_bias_off: got %h required FF00", res);
        else passCount++;
        // Truncated slice has its MSB set but the full accumulator is positive.
        runJob(16'h0000, 1'b1, 32'h0080_0000, 32'h0, res);
        checkCount++;
        if (res !== 16'h8000) $display("[TB] FAIL relu_full_sign: got %h required 8000", res);
        else passCount++;
        runJob(16'h0000, 1'b1, 32'hFFFF_8000, 32'h0, res);
        checkCount++;
        if (res !== 16'h0000) $display("[TB] FAIL relu_small_neg: got %h required 0000", res);
        else passCount++;
    endtask

    task automatic test_trunc();
        logic [15:0] res;
        runJob(16'h0000, 1'b0, 32'h0123_4567, 32'h0, res);
        checkCount++;
        if (res !== 16'h2345) $display("[TB] FAIL trunc_slice: got %h required 2345", res);
        else passCount++;
        runJob(16'h0000, 1'b0, 32'hFFFF_8000, 32'h0, res);
        checkCount++;
        if (res !== 16'hFF80) $display("[TB] FAIL trunc_neg: got %h required FF80", res);
        else passCount++;
        // 0x7FFF0000 + 8 * 0x10000 wraps past the sign bit; bits[23:8] = 0x0700.
        runJob(16'h0000, 1'b0, 32'h7FFF_0000, 32'h0001_0000, res);
        checkCount++;
        if (res !== 16'h0700) $display("[TB] FAIL trunc_wrap: got %h required 0700", res);
        else passCount++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] res;
        startJob(16'h0100, 1'b0);
        for (int i = 0; i < 4; i++) sendBeat(32'h0001_0000);
        rst = 1'b0;
        #1;
        checkCount++;
        if (busy !== 1'b0 || prod_ready !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0 || out_data !== 16'h0000)
            $display("[TB] FAIL reset_mid_async: busy=%b prod_ready=%b out_valid=%b done=%b out_data=%h required 0",
                     busy, prod_ready, out_valid, done, out_data);
        else passCount++;
        nextCycle();
        rst = 1'b1;
        nextCycle();
        runJob(16'h0100, 1'b0, 32'h0001_0000, 32'h0001_0000, res);
        checkCount++;
        if (res !== 16'h0A00) $display("[TB] FAIL reset_mid_residue: got %h required 0A00", res);
        else passCount++;
    endtask

    task automatic test_start_ignored();
        startJob(16'hFF00, 1'b0);
        for (int i = 0; i < 3; i++) sendBeat(32'h0);
        start   = 1'b1;
        bias    = 16'h0100;
        relu_en = 1'b1;
        sendBeat(32'h0);
        start   = 1'b0;
        for (int i = 0; i < 5; i++) sendBeat(32'h0);
        start = 1'b1;
        nextCycle();
        start = 1'b0;
        checkCount++;
        if (out_valid !== 1'b1 || out_data !== 16'hFF00)
            $display("[TB] FAIL start_ignored: out_valid=%b out_data=%h required 1 FF00", out_valid, out_data);
        else passCount++;
        out_ready = 1'b1;
        nextCycle();
        out_ready = 1'b0;
        nextCycle();
    endtask

    task automatic test_back_to_back();
        startJob(16'h0100, 1'b0);
        for (int i = 0; i < 9; i++) sendBeat(32'h0001_0000);
        out_ready = 1'b1;
        nextCycle();
        out_ready = 1'b0;
        checkCount++;
        if (done !== 1'b1) $display("[TB] FAIL b2b_done: done=%b required 1", done);
        else passCount++;
        startJob(16'h0200, 1'b0);
        checkCount++;
        if (busy !== 1'b1 || prod_ready !== 1'b1)
            $display("[TB] FAIL b2b_restart: busy=%b prod_ready=%b required 1 1", busy, prod_ready);
        else passCount++;
        for (int i = 0; i < 9; i++) sendBeat(32'h0001_0000);
        checkCount++;
        if (out_valid !== 1'b1 || out_data !== 16'h0B00)
            $display("[TB] FAIL b2b_result: out_valid=%b out_data=%h required 1 0B00", out_valid, out_data);
        else passCount++;
        out_ready = 1'b1;
        nextCycle();
        out_ready = 1'b0;
        nextCycle();
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        bias       = '0;
        relu_en    = 1'b0;
        prod_valid = 1'b0;
        prod_data  = '0;
        out_ready  = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_gaps();
        test_relu();
        test_trunc();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
